dram_cmd_sequencer: RTL and testbench
=====================================

Name: dram_cmd_sequencer

Overview:
Single-request DRAM command sequencer between the memory-request front end and the DRAM command bus. It accepts one read or write request at a time and classifies it against a per-bank open-row table as HIT, EMPTY or MISS (dram_policy_t). It then steps through PRE/ACT/RDWR/DATA/DONE (dram_command_steps_t), enforcing tRP/tRCD/tCL/tCWL/burst timing with a down-counter. Rows stay open after access (open-page policy).

Parameters:
NUM_BG, 4, number of bank groups
BANKS_PER_BG, 4, banks per bank group
ROW_W, 16, row address width
COL_W, 10, column address width
TRP, 24, PRE-to-ACT delay in clocks (>=1)
TRCD, 24, ACT-to-RDWR delay in clocks (>=1)
TCL, 24, read RDWR-to-first-data delay in clocks (>=1)
TCWL, 20, write RDWR-to-first-data delay in clocks (>=1)
TBURST, 4, data cycles per burst (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_we  in  1  1=write, 0=read
req_bg  in  $clog2(NUM_BG)  bank group
req_bank  in  $clog2(BANKS_PER_BG)  bank within group
req_row  in  ROW_W  row address
req_col  in  COL_W  column address
cmd_valid  out  1  one-cycle command strobe
cmd_step  out  dram_command_steps_t  current step (IDLE/PRE/ACT/RDWR/DATA/DONE)
cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_we  out  as req_*  latched request fields
policy  out  dram_policy_t  classification of the in-flight request (NULL when idle)
data_valid  out  1  high during DATA cycles
done  out  1  one-cycle pulse in DONE

Behaviour:
- Reset: state IDLE, req_ready=1, cmd_valid=0, data_valid=0, done=0, policy=NULL, cmd_* fields 0, all open-row entries invalid. Reset mid-operation aborts immediately; no further commands are issued.
- Accept when req_valid && req_ready (ready only in IDLE). Latch all req_* fields. Bank index = {bg, bank}.
- Classification at accept: entry invalid -> EMPTY; valid and row equal -> HIT; valid and row different -> MISS. policy holds the value until return to IDLE.
- First step is entered on the cycle after accept: MISS->PRE, EMPTY->ACT, HIT->RDWR.
- cmd_valid=1 only in the first cycle of PRE, ACT and RDWR. cmd_step reflects the state every cycle.
- The next step is entered exactly T cycles after the strobe: PRE->ACT after TRP, ACT->RDWR after TRCD, RDWR->DATA after TCL (read) or TCWL (write).
- DATA lasts TBURST cycles with data_valid=1, then DONE for 1 cycle (done=1), then IDLE. req_ready is 1 again in the cycle after DONE, so there is no back-to-back accept in DONE.
- Table update: on entering PRE, invalidate the entry; on entering ACT, set valid and row=cmd_row. Other banks are never touched.
- BANK, BGRP and HIT_LONG..MISS_SHORT encodings are reserved; the FSM never produces them. Any illegal state returns to IDLE.
- Counter width: $clog2(max timing param + 1). It loads T-1 on strobe and decrements to 0.

Decomposition:
- dram_defs holds dram_command_steps_t, dram_policy_t, and new localparam defaults for timing and geometry.
- One sub-module: dram_open_row_table. It is a register array with a combinational lookup (valid, hit) and sync set/invalidate ports, cleared on rst.

Test Plan:
- After reset, read bg1/bank2 row 0x0100 accepted at cycle 0 -> policy EMPTY; ACT strobe c1; RDWR c25; data_valid c49-52; done c53; req_ready c54.
- Repeat read to same bank and row -> policy HIT; RDWR c1; data_valid c25-28; done c29.
- Write to same bank, row 0x0200 -> policy MISS; PRE c1; ACT c25; RDWR c49; data_valid c69-72 (TCWL=20); done c73. Table now holds row 0x0200.
- Read bg0/bank0 row 0x0200 after the above -> EMPTY: the table is per bank, and bg1/bank2 still reports HIT for 0x0200.
- req_valid held high during an operation -> no second accept until the cycle after done; the latched cmd_* fields do not change mid-sequence.
- Assert rst during the TRCD wait of an EMPTY request -> next cycle all outputs are at reset values. A following request to that bank classifies EMPTY, with no PRE issued.

Source files
------------

// File: rtl/dram_cmd_sequencer_pkg.sv
// Shared types and default geometry/timing for the DRAM command sequencer slice.
package dram_defs;

  localparam int unsigned DEF_NUM_BG       = 4;
  localparam int unsigned DEF_BANKS_PER_BG = 4;
  localparam int unsigned DEF_ROW_W        = 16;
  localparam int unsigned DEF_COL_W        = 10;
  localparam int unsigned DEF_TRP          = 24;
  localparam int unsigned DEF_TRCD         = 24;
  localparam int unsigned DEF_TCL          = 24;
  localparam int unsigned DEF_TCWL         = 20;
  localparam int unsigned DEF_TBURST       = 4;

  // BANK and BGRP are reserved encodings; the sequencer never enters them.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    ACT  = 3'd2,
    RDWR = 3'd3,
    DATA = 3'd4,
    DONE = 3'd5,
    BANK = 3'd6,
    BGRP = 3'd7
  } dram_command_steps_t;

  // HIT_LONG..MISS_SHORT are reserved encodings; classification yields only HIT/EMPTY/MISS.
  typedef enum logic [2:0] {
    NULL       = 3'd0,
    HIT        = 3'd1,
    EMPTY      = 3'd2,
    MISS       = 3'd3,
    HIT_LONG   = 3'd4,
    HIT_SHORT  = 3'd5,
    MISS_LONG  = 3'd6,
    MISS_SHORT = 3'd7
  } dram_policy_t;

  function automatic int unsigned max5(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d,
                                       input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/dram_open_row_table.sv
// Per-bank open-row table: combinational lookup, synchronous set/invalidate.
module dram_open_row_table #(
  parameter int unsigned NUM_BANKS = 16,
  parameter int unsigned ROW_W     = 16,
  parameter int unsigned IDX_W     = $clog2(NUM_BANKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_lk_idx,
  input  logic [ROW_W-1:0] i_lk_row,
  output logic             o_lk_valid,
  output logic             o_lk_hit,
  input  logic             i_set,
  input  logic             i_inv,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [ROW_W-1:0] i_wr_row
);

  logic             r_valid [NUM_BANKS];
  logic [ROW_W-1:0] r_row   [NUM_BANKS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        r_valid[i] <= 1'b0;
        r_row[i]   <= '0;
      end
    end else if (i_inv) begin
      r_valid[i_wr_idx] <= 1'b0;
    end else if (i_set) begin
      r_valid[i_wr_idx] <= 1'b1;
      r_row[i_wr_idx]   <= i_wr_row;
    end
  end

  always_comb begin
    o_lk_valid = r_valid[i_lk_idx];
    o_lk_hit   = r_valid[i_lk_idx] && (r_row[i_lk_idx] == i_lk_row);
  end

endmodule

// File: rtl/dram_cmd_sequencer.sv
// Single-request DRAM command sequencer with open-page row tracking and
// down-counter enforcement of tRP/tRCD/tCL/tCWL/burst timing.
module dram_cmd_sequencer
  import dram_defs::*;
#(
  parameter int unsigned NUM_BG       = DEF_NUM_BG,
  parameter int unsigned BANKS_PER_BG = DEF_BANKS_PER_BG,
  parameter int unsigned ROW_W        = DEF_ROW_W,
  parameter int unsigned COL_W        = DEF_COL_W,
  parameter int unsigned TRP          = DEF_TRP,
  parameter int unsigned TRCD         = DEF_TRCD,
  parameter int unsigned TCL          = DEF_TCL,
  parameter int unsigned TCWL         = DEF_TCWL,
  parameter int unsigned TBURST       = DEF_TBURST
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_we,
  input  logic [$clog2(NUM_BG)-1:0]       req_bg,
  input  logic [$clog2(BANKS_PER_BG)-1:0] req_bank,
  input  logic [ROW_W-1:0]                req_row,
  input  logic [COL_W-1:0]                req_col,
  output logic                            cmd_valid,
  output dram_command_steps_t             cmd_step,
  output logic [$clog2(NUM_BG)-1:0]       cmd_bg,
  output logic [$clog2(BANKS_PER_BG)-1:0] cmd_bank,
  output logic [ROW_W-1:0]                cmd_row,
  output logic [COL_W-1:0]                cmd_col,
  output logic                            cmd_we,
  output dram_policy_t                    policy,
  output logic                            data_valid,
  output logic                            done
);

  localparam int unsigned BG_W      = $clog2(NUM_BG);
  localparam int unsigned BK_W      = $clog2(BANKS_PER_BG);
  localparam int unsigned IDX_W     = BG_W + BK_W;
  localparam int unsigned NUM_BANKS = NUM_BG * BANKS_PER_BG;
  localparam int unsigned CNT_W     = $clog2(max5(TRP, TRCD, TCL, TCWL, TBURST) + 1);

  localparam logic [CNT_W-1:0] LD_TRP    = CNT_W'(TRP - 1);
  localparam logic [CNT_W-1:0] LD_TRCD   = CNT_W'(TRCD - 1);
  localparam logic [CNT_W-1:0] LD_TCL    = CNT_W'(TCL - 1);
  localparam logic [CNT_W-1:0] LD_TCWL   = CNT_W'(TCWL - 1);
  localparam logic [CNT_W-1:0] LD_TBURST = CNT_W'(TBURST - 1);

  dram_command_steps_t r_state;
  dram_policy_t        r_policy;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_cmd_valid;
  logic [BG_W-1:0]     r_bg;
  logic [BK_W-1:0]     r_bank;
  logic [ROW_W-1:0]    r_row;
  logic [COL_W-1:0]    r_col;
  logic                r_we;

  logic                w_lk_valid;
  logic                w_lk_hit;
  logic                w_tbl_set;
  logic                w_tbl_inv;
  dram_policy_t        w_class;
  logic                w_cnt_zero;

  // Table writes happen in the strobe cycle of PRE/ACT, using the latched bank and row.
  assign w_tbl_inv = (r_state == PRE) && r_cmd_valid;
  assign w_tbl_set = (r_state == ACT) && r_cmd_valid;

  dram_open_row_table #(
    .NUM_BANKS (NUM_BANKS),
    .ROW_W     (ROW_W),
    .IDX_W     (IDX_W)
  ) u_open_row_table (
    .clk        (clk),
    .rst        (rst),
    .i_lk_idx   ({req_bg, req_bank}),
    .i_lk_row   (req_row),
    .o_lk_valid (w_lk_valid),
    .o_lk_hit   (w_lk_hit),
    .i_set      (w_tbl_set),
    .i_inv      (w_tbl_inv),
    .i_wr_idx   ({r_bg, r_bank}),
    .i_wr_row   (r_row)
  );

  always_comb begin
    w_class = EMPTY;
    if (w_lk_valid) w_class = w_lk_hit ? HIT : MISS;
  end

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_policy    <= NULL;
      r_cnt       <= '0;
      r_cmd_valid <= 1'b0;
      r_bg        <= '0;
      r_bank      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_we        <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_bg        <= req_bg;
            r_bank      <= req_bank;
            r_row       <= req_row;
            r_col       <= req_col;
            r_we        <= req_we;
            r_policy    <= w_class;
            r_cmd_valid <= 1'b1;
            case (w_class)
              MISS: begin
                r_state <= PRE;
                r_cnt   <= LD_TRP;
              end
              EMPTY: begin
                r_state <= ACT;
                r_cnt   <= LD_TRCD;
              end
              default: begin
                r_state <= RDWR;
                r_cnt   <= req_we ? LD_TCWL : LD_TCL;
              end
            endcase
          end
        end
        PRE: begin
          if (w_cnt_zero) begin
            r_state     <= ACT;
            r_cnt       <= LD_TRCD;
            r_cmd_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ACT: begin
          if (w_cnt_zero) begin
            r_state     <= RDWR;
            r_cnt       <= r_we ? LD_TCWL : LD_TCL;
            r_cmd_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RDWR: begin
          if (w_cnt_zero) begin
            r_state <= DATA;
            r_cnt   <= LD_TBURST;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DATA: begin
          if (w_cnt_zero) r_state <= DONE;
          else            r_cnt   <= r_cnt - 1'b1;
        end
        DONE: begin
          r_state  <= IDLE;
          r_policy <= NULL;
        end
        default: begin
          r_state  <= IDLE;
          r_policy <= NULL;
          r_cnt    <= '0;
        end
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign cmd_valid  = r_cmd_valid;
  assign cmd_step   = r_state;
  assign cmd_bg     = r_bg;
  assign cmd_bank   = r_bank;
  assign cmd_row    = r_row;
  assign cmd_col    = r_col;
  assign cmd_we     = r_we;
  assign policy     = r_policy;
  assign data_valid = (r_state == DATA);
  assign done       = (r_state == DONE);

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Directed self-checking bench for dram_cmd_sequencer (default parameters).
module tb_dram_cmd_sequencer;
  import dram_defs::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [1:0]          req_bg;
  logic [1:0]          req_bank;
  logic [15:0]         req_row;
  logic [9:0]          req_col;
  logic                cmd_valid;
  dram_command_steps_t cmd_step;
  logic [1:0]          cmd_bg;
  logic [1:0]          cmd_bank;
  logic [15:0]         cmd_row;
  logic [9:0]          cmd_col;
  logic                cmd_we;
  dram_policy_t        policy;
  logic                data_valid;
  logic                done;

  int errors = 0;
  int checks = 0;

  // Trace of the most recent request, cycle numbers relative to the accept cycle (0).
  int           t_pre, t_act, t_rdwr, t_dv_first, t_dv_cnt, t_done, t_ready;
  dram_policy_t t_pol, t_pol_idle;
  bit           t_accepted, t_fields_ok, t_seq_ok;

  always #5 clk = ~clk;

  dram_cmd_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_bg     (req_bg),
    .req_bank   (req_bank),
    .req_row    (req_row),
    .req_col    (req_col),
    .cmd_valid  (cmd_valid),
    .cmd_step   (cmd_step),
    .cmd_bg     (cmd_bg),
    .cmd_bank   (cmd_bank),
    .cmd_row    (cmd_row),
    .cmd_col    (cmd_col),
    .cmd_we     (cmd_we),
    .policy     (policy),
    .data_valid (data_valid),
    .done       (done)
  );

  // Drives one request from a negedge and records when each event is seen (bounded).
  task automatic issue(input logic we, input logic [1:0] bg, input logic [1:0] bank,
                       input logic [15:0] row, input logic [9:0] col, input bit hold);
    t_pre = -1; t_act = -1; t_rdwr = -1; t_dv_first = -1; t_dv_cnt = 0;
    t_done = -1; t_ready = -1; t_pol = NULL; t_pol_idle = MISS_SHORT;
    t_fields_ok = 1'b1; t_seq_ok = 1'b1;
    req_we = we; req_bg = bg; req_bank = bank; req_row = row; req_col = col;
    req_valid = 1'b1;
    t_accepted = req_ready;
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    else begin
      req_we = ~we; req_bg = ~bg; req_bank = ~bank; req_row = ~row; req_col = ~col;
    end
    for (int cyc = 1; cyc <= 150; cyc++) begin
      if (cyc == 1) t_pol = policy;
      if (req_ready) begin
        t_ready    = cyc;
        t_pol_idle = policy;
        req_valid  = 1'b0;
        break;
      end
      if (policy !== t_pol) t_seq_ok = 1'b0;
      if (cmd_valid) begin
        case (cmd_step)
          PRE:     t_pre  = cyc;
          ACT:     t_act  = cyc;
          RDWR:    t_rdwr = cyc;
          default: t_seq_ok = 1'b0;
        endcase
      end
      if (data_valid) begin
        if (t_dv_first < 0) t_dv_first = cyc;
        t_dv_cnt++;
        if (cmd_step !== DATA) t_seq_ok = 1'b0;
      end
      if (done) t_done = cyc;
      if (cmd_we !== we || cmd_bg !== bg || cmd_bank !== bank ||
          cmd_row !== row || cmd_col !== col) t_fields_ok = 1'b0;
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0d expected 1", req_ready); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %0d expected 0", cmd_valid); end
    checks++; if (cmd_step !== IDLE) begin errors++; $display("FAIL reset_step: got %0d expected %0d", cmd_step, IDLE); end
    checks++; if (policy !== NULL) begin errors++; $display("FAIL reset_policy: got %0d expected %0d", policy, NULL); end
    checks++; if (data_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_dv_done: got %0d/%0d expected 0/0", data_valid, done); end
    checks++; if ({cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_we} !== '0) begin errors++; $display("FAIL reset_fields: got %0h expected 0", {cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_we}); end
  endtask

  task automatic test_empty_read;
    issue(1'b0, 2'd1, 2'd2, 16'h0100, 10'h011, 1'b0);
    checks++; if (t_accepted !== 1'b1) begin errors++; $display("FAIL empty_accept: got %0d expected 1", t_accepted); end
    checks++; if (t_pol !== EMPTY) begin errors++; $display("FAIL empty_policy: got %0d expected %0d", t_pol, EMPTY); end
    checks++; if (t_pre !== -1 || t_act !== 1) begin errors++; $display("FAIL empty_pre_act: got %0d/%0d expected -1/1", t_pre, t_act); end
    checks++; if (t_rdwr !== 25) begin errors++; $display("FAIL empty_rdwr: got %0d expected 25", t_rdwr); end
    checks++; if (t_dv_first !== 49 || t_dv_cnt !== 4) begin errors++; $display("FAIL empty_data: got first %0d cnt %0d expected 49 4", t_dv_first, t_dv_cnt); end
    checks++; if (t_done !== 53 || t_ready !== 54) begin errors++; $display("FAIL empty_done_ready: got %0d/%0d expected 53/54", t_done, t_ready); end
    checks++; if (t_fields_ok !== 1'b1 || t_seq_ok !== 1'b1) begin errors++; $display("FAIL empty_fields_seq: got %0d/%0d expected 1/1", t_fields_ok, t_seq_ok); end
    checks++; if (t_pol_idle !== NULL) begin errors++; $display("FAIL empty_policy_idle: got %0d expected %0d", t_pol_idle, NULL); end
  endtask

  task automatic test_hit_read;
    issue(1'b0, 2'd1, 2'd2, 16'h0100, 10'h022, 1'b0);
    checks++; if (t_pol !== HIT) begin errors++; $display("FAIL hit_policy: got %0d expected %0d", t_pol, HIT); end
    checks++; if (t_pre !== -1 || t_act !== -1 || t_rdwr !== 1) begin errors++; $display("FAIL hit_cmds: got %0d/%0d/%0d expected -1/-1/1", t_pre, t_act, t_rdwr); end
    checks++; if (t_dv_first !== 25 || t_dv_cnt !== 4) begin errors++; $display("FAIL hit_data: got first %0d cnt %0d expected 25 4", t_dv_first, t_dv_cnt); end
    checks++; if (t_done !== 29 || t_ready !== 30) begin errors++; $display("FAIL hit_done_ready: got %0d/%0d expected 29/30", t_done, t_ready); end
  endtask

  task automatic test_miss_write;
    issue(1'b1, 2'd1, 2'd2, 16'h0200, 10'h3ff, 1'b0);
    checks++; if (t_pol !== MISS) begin errors++; $display("FAIL miss_policy: got %0d expected %0d", t_pol, MISS); end
    checks++; if (t_pre !== 1 || t_act !== 25 || t_rdwr !== 49) begin errors++; $display("FAIL miss_cmds: got %0d/%0d/%0d expected 1/25/49", t_pre, t_act, t_rdwr); end
    checks++; if (t_dv_first !== 69 || t_dv_cnt !== 4) begin errors++; $display("FAIL miss_data: got first %0d cnt %0d expected 69 4", t_dv_first, t_dv_cnt); end
    checks++; if (t_done !== 73 || t_ready !== 74) begin errors++; $display("FAIL miss_done_ready: got %0d/%0d expected 73/74", t_done, t_ready); end
    checks++; if (t_fields_ok !== 1'b1 || t_seq_ok !== 1'b1) begin errors++; $display("FAIL miss_fields_seq: got %0d/%0d expected 1/1", t_fields_ok, t_seq_ok); end
  endtask

  task automatic test_per_bank;
    issue(1'b0, 2'd0, 2'd0, 16'h0200, 10'h000, 1'b0);
    checks++; if (t_pol !== EMPTY || t_act !== 1) begin errors++; $display("FAIL other_bank_empty: got pol %0d act %0d expected %0d 1", t_pol, t_act, EMPTY); end
    checks++; if (t_done !== 53) begin errors++; $display("FAIL other_bank_done: got %0d expected 53", t_done); end
  endtask

  task automatic test_back_to_back;
    issue(1'b0, 2'd1, 2'd2, 16'h0200, 10'h155, 1'b1);
    checks++; if (t_pol !== HIT || t_rdwr !== 1) begin errors++; $display("FAIL hold_hit: got pol %0d rdwr %0d expected %0d 1", t_pol, t_rdwr, HIT); end
    checks++; if (t_fields_ok !== 1'b1) begin errors++; $display("FAIL hold_fields_stable: got %0d expected 1", t_fields_ok); end
    checks++; if (t_done !== 29 || t_ready !== 30) begin errors++; $display("FAIL hold_no_early_accept: got done %0d ready %0d expected 29 30", t_done, t_ready); end
    @(negedge clk);
    checks++; if (cmd_step !== IDLE || req_ready !== 1'b1) begin errors++; $display("FAIL hold_idle_after: got step %0d ready %0d expected %0d 1", cmd_step, req_ready, IDLE); end
  endtask

  task automatic test_reset_mid_op;
    req_we = 1'b0; req_bg = 2'd2; req_bank = 2'd3; req_row = 16'h0055; req_col = 10'h001;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (cmd_valid !== 1'b1 || cmd_step !== ACT) begin errors++; $display("FAIL abort_act_strobe: got %0d/%0d expected 1/%0d", cmd_valid, cmd_step, ACT); end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (cmd_step !== IDLE || req_ready !== 1'b1 || policy !== NULL) begin errors++; $display("FAIL abort_state: got step %0d ready %0d pol %0d expected %0d 1 %0d", cmd_step, req_ready, policy, IDLE, NULL); end
    checks++; if ({cmd_valid, data_valid, done} !== 3'b000 || {cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_we} !== '0) begin errors++; $display("FAIL abort_outputs: got %0b fields %0h expected 000 0", {cmd_valid, data_valid, done}, {cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_we}); end
    issue(1'b0, 2'd2, 2'd3, 16'h0055, 10'h002, 1'b0);
    checks++; if (t_pol !== EMPTY || t_pre !== -1 || t_act !== 1) begin errors++; $display("FAIL abort_reissue: got pol %0d pre %0d act %0d expected %0d -1 1", t_pol, t_pre, t_act, EMPTY); end
    issue(1'b1, 2'd1, 2'd2, 16'h0200, 10'h002, 1'b0);
    checks++; if (t_pol !== EMPTY || t_pre !== -1 || t_dv_first !== 45) begin errors++; $display("FAIL abort_table_cleared: got pol %0d pre %0d dv %0d expected %0d -1 45", t_pol, t_pre, t_dv_first, EMPTY); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_bg = '0; req_bank = '0; req_row = '0; req_col = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_empty_read;
    test_hit_read;
    test_miss_write;
    test_per_bank;
    test_back_to_back;
    test_reset_mid_op;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
